// File: rtl/io_tile_pkg.sv
// Shared sizing and shadow-field layout helpers for the shadowed IO tile.
package io_tile_pkg;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int pad_w(input int sel_o);
        return sel_o + 3;
    endfunction

    function automatic int config_width(input int io_count, input int ic_width);
        return io_count * pad_w(clog2(ic_width)) + ic_width * clog2(io_count + 1);
    endfunction

    function automatic int pad_base(input int i, input int pw);
        return i * pw;
    endfunction

    function automatic int ic_base(input int j, input int io_count, input int pw, input int sel_i);
        return io_count * pw + j * sel_i;
    endfunction

    function automatic int out_reg_off(input int sel_o);
        return sel_o;
    endfunction

    function automatic int in_reg_off(input int sel_o);
        return sel_o + 1;
    endfunction

    function automatic int oe_off(input int sel_o);
        return sel_o + 2;
    endfunction

endpackage

// File: rtl/io_tile_config_shadow.sv
// Serial config chain with frame-length check; commits a complete frame into the shadow.
module io_tile_config_shadow
    import io_tile_pkg::*;
#(
    parameter int CONFIG_WIDTH = 58
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    config_in,
    input  logic                    config_enable,
    input  logic                    config_commit,
    output logic                    config_out,
    output logic                    config_active,
    output logic                    config_error,
    output logic [CONFIG_WIDTH-1:0] shadow
);

    localparam int CNT_W = clog2(CONFIG_WIDTH + 2);

    logic [CONFIG_WIDTH-1:0] sr;
    logic [CNT_W-1:0]        cnt;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sr            <= '0;
            cnt           <= '0;
            shadow        <= '0;
            config_active <= 1'b0;
            config_error  <= 1'b0;
        end else if (config_enable) begin
            sr <= {sr[CONFIG_WIDTH-2:0], config_in};
            // Saturating one past a full frame keeps over-length frames distinguishable.
            if (cnt != CNT_W'(CONFIG_WIDTH + 1)) cnt <= cnt + 1'b1;
            if (config_commit) config_error <= 1'b1;
        end else if (config_commit) begin
            cnt <= '0;
            if (cnt == CNT_W'(CONFIG_WIDTH)) begin
                shadow        <= sr;
                config_active <= 1'b1;
                config_error  <= 1'b0;
            end else begin
                config_error  <= 1'b1;
            end
        end
    end

    assign config_out = sr[CONFIG_WIDTH-1];

endmodule

// File: rtl/io_tile_shadowed.sv
// Parametrised IO tile: per-pad routing with optional registering, driven by a committed shadow config.
module io_tile_shadowed
    import io_tile_pkg::*;
#(
    parameter int IO_COUNT = 4,
    parameter int IC_WIDTH = 10
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                config_in,
    output logic                config_out,
    input  logic                config_enable,
    input  logic                config_commit,
    output logic                config_active,
    output logic                config_error,
    input  logic [IO_COUNT-1:0] data_from_io,
    output logic [IO_COUNT-1:0] data_to_io,
    output logic [IO_COUNT-1:0] io_oe,
    input  logic [IC_WIDTH-1:0] data_from_ic,
    output logic [IC_WIDTH-1:0] data_to_ic
);

    localparam int SEL_O        = clog2(IC_WIDTH);
    localparam int SEL_I        = clog2(IO_COUNT + 1);
    localparam int PAD_W        = pad_w(SEL_O);
    localparam int CONFIG_WIDTH = config_width(IO_COUNT, IC_WIDTH);

    logic [CONFIG_WIDTH-1:0] shadow;
    logic [IO_COUNT-1:0]     v, p, qo, qi, to_io_raw, oe_raw;
    logic [IC_WIDTH-1:0]     to_ic_raw;

    io_tile_config_shadow #(
        .CONFIG_WIDTH(CONFIG_WIDTH)
    ) u_cfg (
        .clock        (clock),
        .nreset       (nreset),
        .config_in    (config_in),
        .config_enable(config_enable),
        .config_commit(config_commit),
        .config_out   (config_out),
        .config_active(config_active),
        .config_error (config_error),
        .shadow       (shadow)
    );

    // Selects are matched against each legal index, so out-of-range codes fall through to 0.
    always_comb begin
        v         = '0;
        p         = '0;
        to_io_raw = '0;
        oe_raw    = '0;
        to_ic_raw = '0;
        for (int unsigned i = 0; i < IO_COUNT; i++) begin
            for (int unsigned k = 0; k < IC_WIDTH; k++) begin
                if (shadow[pad_base(i, PAD_W) +: SEL_O] == SEL_O'(k)) v[i] = data_from_ic[k];
            end
            to_io_raw[i] = shadow[pad_base(i, PAD_W) + out_reg_off(SEL_O)] ? qo[i] : v[i];
            p[i]         = shadow[pad_base(i, PAD_W) + in_reg_off(SEL_O)] ? qi[i] : data_from_io[i];
            oe_raw[i]    = shadow[pad_base(i, PAD_W) + oe_off(SEL_O)];
        end
        for (int unsigned j = 0; j < IC_WIDTH; j++) begin
            for (int unsigned k = 0; k < IO_COUNT; k++) begin
                if (shadow[ic_base(j, IO_COUNT, PAD_W, SEL_I) +: SEL_I] == SEL_I'(k)) to_ic_raw[j] = p[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            qo <= '0;
            qi <= '0;
        end else begin
            qo <= v;
            qi <= data_from_io;
        end
    end

    assign data_to_io = config_active ? to_io_raw : '0;
    assign io_oe      = config_active ? oe_raw : '0;
    assign data_to_ic = config_active ? to_ic_raw : '0;

endmodule

// File: tb/tb_io_tile_shadowed.sv
// Randomised and directed bench for io_tile_shadowed against a field-level reference model.
module tb_io_tile_shadowed;

    localparam int IO = 4;
    localparam int IC = 10;
    localparam int SO = 4;
    localparam int SI = 3;
    localparam int PW = 7;
    localparam int CW = 58;

    logic          clock;
    logic          nreset;
    logic          config_in, config_enable, config_commit;
    logic          config_out, config_active, config_error;
    logic [IO-1:0] data_from_io, data_to_io, io_oe;
    logic [IC-1:0] data_from_ic, data_to_ic;

    int checks = 0;
    int errors = 0;
    bit rand_data = 1;

    // Reference state: chain contents as a bit queue (index 0 = MSB), decoded committed fields.
    bit      m_q[$];
    int      m_cnt;
    bit      m_active, m_error;
    int      m_out_sel[IO];
    bit      m_out_reg[IO], m_in_reg[IO], m_oe[IO];
    int      m_in_sel[IC];
    bit      m_qo[IO], m_qi[IO];

    io_tile_shadowed #(
        .IO_COUNT(IO),
        .IC_WIDTH(IC)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .config_in    (config_in),
        .config_out   (config_out),
        .config_enable(config_enable),
        .config_commit(config_commit),
        .config_active(config_active),
        .config_error (config_error),
        .data_from_io (data_from_io),
        .data_to_io   (data_to_io),
        .io_oe        (io_oe),
        .data_from_ic (data_from_ic),
        .data_to_ic   (data_to_ic)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sr_field(input int base, input int width);
        int val;
        val = 0;
        for (int b = 0; b < width; b++)
            if (m_q[CW-1-(base+b)]) val |= (1 << b);
        return val;
    endfunction

    function automatic bit pad_v(input int i);
        return (m_out_sel[i] < IC) ? data_from_ic[m_out_sel[i]] : 1'b0;
    endfunction

    task automatic model_edge();
        if (!nreset) begin
            m_q.delete();
            repeat (CW) m_q.push_back(1'b0);
            m_cnt = 0; m_active = 0; m_error = 0;
            for (int i = 0; i < IO; i++) begin
                m_out_sel[i] = 0; m_out_reg[i] = 0; m_in_reg[i] = 0; m_oe[i] = 0;
                m_qo[i] = 0; m_qi[i] = 0;
            end
            for (int j = 0; j < IC; j++) m_in_sel[j] = 0;
            return;
        end
        for (int i = 0; i < IO; i++) begin
            m_qo[i] = pad_v(i);
            m_qi[i] = data_from_io[i];
        end
        if (config_enable) begin
            m_q.push_back(config_in);
            void'(m_q.pop_front());
            if (m_cnt < CW + 1) m_cnt++;
            if (config_commit) m_error = 1;
        end else if (config_commit) begin
            if (m_cnt == CW) begin
                for (int i = 0; i < IO; i++) begin
                    m_out_sel[i] = sr_field(i*PW, SO);
                    m_out_reg[i] = sr_field(i*PW + SO, 1) != 0;
                    m_in_reg[i]  = sr_field(i*PW + SO + 1, 1) != 0;
                    m_oe[i]      = sr_field(i*PW + SO + 2, 1) != 0;
                end
                for (int j = 0; j < IC; j++) m_in_sel[j] = sr_field(IO*PW + j*SI, SI);
                m_active = 1;
                m_error  = 0;
            end else begin
                m_error = 1;
            end
            m_cnt = 0;
        end
    endtask

    task automatic check_all();
        logic [IO-1:0] e_io, e_oe, pv;
        logic [IC-1:0] e_ic;
        e_io = '0; e_oe = '0; e_ic = '0; pv = '0;
        if (m_active) begin
            for (int i = 0; i < IO; i++) begin
                e_io[i] = m_out_reg[i] ? m_qo[i] : pad_v(i);
                e_oe[i] = m_oe[i];
                pv[i]   = m_in_reg[i] ? m_qi[i] : data_from_io[i];
            end
            for (int j = 0; j < IC; j++) e_ic[j] = (m_in_sel[j] < IO) ? pv[m_in_sel[j]] : 1'b0;
        end
        check_eq("config_out", 32'(config_out), 32'(m_q[0]));
        check_eq("config_active", 32'(config_active), 32'(m_active));
        check_eq("config_error", 32'(config_error), 32'(m_error));
        check_eq("data_to_io", 32'(data_to_io), 32'(e_io));
        check_eq("io_oe", 32'(io_oe), 32'(e_oe));
        check_eq("data_to_ic", 32'(data_to_ic), 32'(e_ic));
    endtask

    task automatic step(input logic en, input logic cm, input logic cin);
        config_enable = en;
        config_commit = cm;
        config_in     = cin;
        @(posedge clock);
        model_edge();
        #1;
        if (rand_data) begin
            data_from_ic = IC'($urandom);
            data_from_io = IO'($urandom);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        nreset = 1'b1;
    endtask

    // Bit 0 of the stream is frame[CW-1], so a full frame lands with its MSB at the chain MSB.
    task automatic shift_bits(input logic [CW-1:0] f, input int n);
        for (int k = 0; k < n; k++)
            step(1, 0, (k < CW) ? f[CW-1-k] : 1'($urandom));
    endtask

    function automatic logic [CW-1:0] put(input logic [CW-1:0] f, input int base,
                                          input int width, input int val);
        for (int b = 0; b < width; b++) f[base+b] = val[b];
        return f;
    endfunction

    function automatic logic [CW-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CW-1:0];
    endfunction

    initial begin
        logic [CW-1:0] fa, fb;
        int n, r;
        nreset = 1'b0; config_in = 0; config_enable = 0; config_commit = 0;
        data_from_ic = '0; data_from_io = '0;

        do_reset();
        check_eq("reset_active", 32'(config_active), 32'd0);
        check_eq("reset_error", 32'(config_error), 32'd0);

        // Frame A: pad0 from track 3 with oe, track 2 from pad 1.
        fa = '0;
        fa = put(fa, 0, SO, 3);
        fa = put(fa, SO + 2, 1, 1);
        fa = put(fa, IO*PW + 2*SI, SI, 1);
        shift_bits(fa, CW);
        step(0, 1, 0);
        check_eq("a_active", 32'(config_active), 32'd1);
        check_eq("a_error", 32'(config_error), 32'd0);
        rand_data = 0;
        data_from_ic = 10'b00_0000_1000;
        data_from_io = 4'b0010;
        #1;
        check_eq("a_oe0", 32'(io_oe[0]), 32'd1);
        check_eq("a_to_io0", 32'(data_to_io[0]), 32'd1);
        check_eq("a_to_ic2", 32'(data_to_ic[2]), 32'd1);
        data_from_ic = '0;
        data_from_io = '0;
        #1;
        check_eq("a_to_io0_low", 32'(data_to_io[0]), 32'd0);
        check_eq("a_to_ic2_low", 32'(data_to_ic[2]), 32'd0);
        rand_data = 1;

        // Short frame from reset, then a full frame recovers.
        do_reset();
        shift_bits(fa, CW - 1);
        step(0, 1, 0);
        check_eq("short_error", 32'(config_error), 32'd1);
        check_eq("short_active", 32'(config_active), 32'd0);
        shift_bits(fa, CW);
        step(0, 1, 0);
        check_eq("recover_error", 32'(config_error), 32'd0);

        // Over-length frame is rejected; shadow stays on frame A.
        shift_bits(rand_frame(), CW + 1);
        step(0, 1, 0);
        check_eq("long_error", 32'(config_error), 32'd1);
        check_eq("long_oe0", 32'(io_oe[0]), 32'd1);

        // Registered paths: pad0 out_reg, pad1 in_reg feeding track 2.
        fb = fa;
        fb = put(fb, SO, 1, 1);
        fb = put(fb, PW + SO + 1, 1, 1);
        shift_bits(fb, CW);
        step(0, 1, 0);
        rand_data = 0;
        data_from_ic = '0; data_from_io = '0;
        step(0, 0, 0);
        data_from_ic[3] = 1'b1;
        data_from_io[1] = 1'b1;
        #1;
        check_eq("outreg_n", 32'(data_to_io[0]), 32'd0);
        check_eq("inreg_n", 32'(data_to_ic[2]), 32'd0);
        step(0, 0, 0);
        check_eq("outreg_n1", 32'(data_to_io[0]), 32'd1);
        check_eq("inreg_n1", 32'(data_to_ic[2]), 32'd1);
        rand_data = 1;

        // Reload while running; the model checks outputs and config_out every shift.
        shift_bits(rand_frame(), CW);
        step(0, 1, 0);

        // Commit with enable: shift happens, commit refused.
        step(1, 1, 1);
        check_eq("both_error", 32'(config_error), 32'd1);

        // Reset mid-frame discards the partial frame.
        shift_bits(rand_frame(), 20);
        do_reset();
        shift_bits(fa, CW);
        step(0, 1, 0);
        check_eq("post_reset_active", 32'(config_active), 32'd1);
        check_eq("post_reset_error", 32'(config_error), 32'd0);

        for (int it = 0; it < 150; it++) begin
            r = int'($urandom % 16);
            if (r == 0) begin
                nreset = 1'b0;
                step(0, 0, 1'($urandom));
                nreset = 1'b1;
            end
            n = (r < 10) ? CW : 55 + int'($urandom % 6);
            fb = rand_frame();
            for (int k = 0; k < n; k++) begin
                while ($urandom % 8 == 0) step(0, 0, 1'($urandom));
                step(1, 0, (k < CW) ? fb[CW-1-k] : 1'($urandom));
            end
            if ($urandom % 6 == 0) step(1, 1, 1'($urandom));
            else step(0, 1, 0);
            repeat (int'($urandom % 4)) step(0, 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
